// File: rtl/rega_pkg.sv
// Shared encodings for the irrigation sequencer: FSM states, mef1 output codes
// and the bit positions of the two irrigation valves inside rega.
package rega_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENCHENDO = 3'd1,
        REGANDO  = 3'd2,
        LIMPANDO = 3'd3,
        ERRO     = 3'd4
    } estado_t;

    localparam logic [1:0] MEF_OCIOSO = 2'b00;
    localparam logic [1:0] MEF_ENCH   = 2'b01;
    localparam logic [1:0] MEF_LIMP   = 2'b10;
    localparam logic [1:0] MEF_REGA   = 2'b11;

    localparam int REGA_ASP = 1;
    localparam int REGA_GOT = 0;

    // ERRO deliberately shares the idle code; the fault is flagged on erro.
    function automatic logic [1:0] mef_code(input estado_t e);
        case (e)
            ENCHENDO: mef_code = MEF_ENCH;
            REGANDO:  mef_code = MEF_REGA;
            LIMPANDO: mef_code = MEF_LIMP;
            default:  mef_code = MEF_OCIOSO;
        endcase
    endfunction

endpackage

// File: rtl/controlador_rega_contador.sv
// contador_rega: CNT_W duration counter with clear, enable/hold and a
// terminal-count flag against a limit chosen at run time by the FSM.
module contador_rega #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limite_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == limite_i);

endmodule

// File: rtl/controlador_rega.sv
// controlador_rega: Moore sequencer for tank fill, sprinkler/drip irrigation,
// cleaning and fault latching. Optional fill watchdog: ENCHIMENTO_TIMEOUT_EN.
module controlador_rega
    import rega_pkg::*;
#(
    parameter int T_REGA = 100,
    parameter int T_LIMP = 50,
    parameter int T_ENCH = 200,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       asp,
    input  logic       got,
    input  logic       limpeza,
    input  logic       nivel_min,
    input  logic       nivel_max,
    input  logic       ack_erro,
    output logic [1:0] mef1,
    output logic [1:0] rega,
    output logic       VE,
    output logic       dreno,
    output logic       erro
);

    localparam logic [CNT_W-1:0] LIM_REGA = CNT_W'(T_REGA - 1);
    localparam logic [CNT_W-1:0] LIM_LIMP = CNT_W'(T_LIMP - 1);
    localparam int MAX_RL = (T_REGA > T_LIMP) ? T_REGA : T_LIMP;
    localparam int MAX_T  = (MAX_RL > T_ENCH) ? MAX_RL : T_ENCH;

    estado_t          estado_q, estado_d;
    logic             modo_q, modo_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_lim;
    logic [1:0]       mef1_q, mef1_d, rega_q, rega_d;
    logic             ve_q, ve_d, dreno_q, dreno_d, erro_q, erro_d;

    contador_rega #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .limite_i (cnt_lim),
        .tc_o     (cnt_tc)
    );

`ifdef ENCHIMENTO_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LIM_ENCH = CNT_W'(T_ENCH - 1);
    logic ench_tc;

    // Held at zero outside ENCHENDO, so every fill attempt starts from 0.
    contador_rega #(.CNT_W(CNT_W)) u_cnt_ench (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (estado_q != ENCHENDO),
        .en_i     (estado_q == ENCHENDO),
        .limite_i (LIM_ENCH),
        .tc_o     (ench_tc)
    );
`endif

    always_comb begin
        estado_d = estado_q;
        modo_d   = modo_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_lim  = LIM_REGA;
        case (estado_q)
            OCIOSO: begin
                // Idle also scrubs any count left behind by an aborted run.
                cnt_clr = 1'b1;
                if (asp && got)
                    estado_d = ERRO;
                else if (limpeza)
                    estado_d = LIMPANDO;
                else if (asp ^ got) begin
                    modo_d   = asp;
                    estado_d = nivel_min ? REGANDO : ENCHENDO;
                end
            end
            ENCHENDO: begin
                if (nivel_max)
                    estado_d = REGANDO;
`ifdef ENCHIMENTO_TIMEOUT_EN
                else if (ench_tc) begin
                    estado_d = ERRO;
                    cnt_clr  = 1'b1;
                end
`endif
            end
            REGANDO: begin
                cnt_en = 1'b1;
                if (asp && got)
                    estado_d = ERRO;
                else if (cnt_tc) begin
                    cnt_clr  = 1'b1;
                    estado_d = OCIOSO;
                end else if (!nivel_min)
                    estado_d = ENCHENDO;
            end
            LIMPANDO: begin
                cnt_lim = LIM_LIMP;
                cnt_en  = 1'b1;
                if (cnt_tc) begin
                    cnt_clr  = 1'b1;
                    estado_d = OCIOSO;
                end
            end
            ERRO: begin
                cnt_clr = 1'b1;
                if (ack_erro && !asp && !got)
                    estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        mef1_d  = mef_code(estado_d);
        rega_d  = 2'b00;
        if (estado_d == REGANDO) begin
            if (modo_d)
                rega_d[REGA_ASP] = 1'b1;
            else
                rega_d[REGA_GOT] = 1'b1;
        end
        ve_d    = (estado_d == ENCHENDO);
        dreno_d = (estado_d == LIMPANDO);
        erro_d  = (estado_d == ERRO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            modo_q   <= 1'b0;
            mef1_q   <= 2'b00;
            rega_q   <= 2'b00;
            ve_q     <= 1'b0;
            dreno_q  <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            modo_q   <= modo_d;
            mef1_q   <= mef1_d;
            rega_q   <= rega_d;
            ve_q     <= ve_d;
            dreno_q  <= dreno_d;
            erro_q   <= erro_d;
        end
    end

    assign mef1  = mef1_q;
    assign rega  = rega_q;
    assign VE    = ve_q;
    assign dreno = dreno_q;
    assign erro  = erro_q;

    a_ve_rega:   assert property (@(posedge clk) !(VE && (|rega)));
    a_rega_one:  assert property (@(posedge clk) rega != 2'b11);
    a_dreno:     assert property (@(posedge clk) dreno |-> (rega == 2'b00 && !VE));
    a_cnt_width: assert property (@(posedge clk) (2 ** CNT_W) > MAX_T);

endmodule
